axi_lite_master: RTL and testbench
==================================

# axi_lite_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into one AXI4-Lite read or write transaction. It drives the opposite end of the bus from `axi_lite_bram` and is the bus-side engine that test controllers and the UART/command front end use to reach any AXI4-Lite responder in the design. Only one transaction is in flight at a time. Write address and write data are issued concurrently and completed independently.

## Interface
- ADDR_WIDTH, 8, byte address width of AWADDR/ARADDR/cmd_addr
- DATA_WIDTH, 8, data width; strobe width is DATA_WIDTH/8
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  synchronous, active-low reset: one clock, reset is synchronous and active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  DATA_WIDTH/8  write strobes (ignored for reads)
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_rdata  out  DATA_WIDTH  captured RDATA (reads); holds previous value on writes
- rsp_resp  out  2  captured BRESP or RRESP
- rsp_write  out  1  echo of cmd_write for this result
- AWVALID out 1, AWREADY in 1, AWADDR out ADDR_WIDTH
- WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH, WSTRB out DATA_WIDTH/8
- BVALID in 1, BREADY out 1, BRESP in 2
- ARVALID out 1, ARREADY in 1, ARADDR out ADDR_WIDTH
- RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RRESP in 2

## Operation
- States: IDLE, WR_AW_W, WR_RESP, RD_AR, RD_DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/wdata/wstrb/write into AWADDR/WDATA/WSTRB or ARADDR.
  - Go to WR_AW_W with AWVALID=WVALID=1, or to RD_AR with ARVALID=1.
- WR_AW_W:
  - Per-channel done flags aw_done and w_done.
  - AWVALID clears the edge after AWVALID&&AWREADY. WVALID clears the edge after WVALID&&WREADY. Each channel is independent, in any order or simultaneously.
  - When both are done (including same-edge completion), go to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID, capture BRESP into rsp_resp and go to RESP.
  - A BVALID already high on entry is accepted on the first cycle.
- RD_AR: ARVALID=1 until ARREADY, then go to RD_DATA with ARVALID=0.
- RD_DATA: RREADY=1. On RVALID, capture RDATA and RRESP, then go to RESP.
- RESP: rsp_valid=1 held until rsp_ready, then go to IDLE. No AXI valid/ready is asserted in RESP.
- BREADY and RREADY are never high outside WR_RESP and RD_DATA respectively.
- AXI payload stability: AWADDR/WDATA/WSTRB/ARADDR are constant while the corresponding VALID is high and hold their values afterwards.
- BRESP/RRESP are passed through unmodified, including SLVERR and DECERR. The master never retries.

## Timing
- Reset (ARESETN low at a rising edge): state=IDLE; all VALID/READY outputs 0; AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_write all 0; rsp_valid=0.
- cmd_ready=1 from the first edge after release.
- Reset mid-transaction: at the next edge the block aborts to IDLE and all VALIDs drop. The responder must be reset in the same cycle.
- Command accepted at edge N (end of cycle with cmd_valid&&cmd_ready):
  - AXI VALID(s) are high in cycle N+1.
  - cmd_ready is low from N+1 until the cycle after rsp handshake.
- VALIDs are registered outputs and never depend combinationally on READY inputs.
- Against `axi_lite_bram` (registered single-cycle READY, registered B/R):
  - Read: ARREADY in N+2, RVALID in N+3, rsp_valid in N+4.
  - Write: AWREADY/WREADY in N+2, BVALID in N+3, rsp_valid in N+4.
- Back-to-back commands: minimum 5 cycles per transaction. cmd_ready returns the cycle after rsp_valid&&rsp_ready.
- A responder READY or VALID that is high before the master's VALID/READY completes no handshake until both are high.

## Test plan
- Read with `axi_lite_bram` preloaded bram[i]=i: cmd read addr 0x3C -> rsp_valid in N+4 with rsp_rdata=0x3C, rsp_resp=00, rsp_write=0.
- Write then read: write 0xA5 to 0x10 with wstrb=1 -> rsp_resp=00. A following read of 0x10 -> rsp_rdata=0xA5.
- Masked write: write 0xFF to 0x20 with wstrb=0 -> rsp_resp=00. A following read of 0x20 -> 0x20.
- Split write channels with a stub responder (AWREADY at N+1, WREADY at N+4, BRESP=10):
  - AWVALID drops at N+2; WVALID stays high through N+4.
  - BREADY stays 0 until N+5.
  - rsp_resp=10.
- Response back-pressure: rsp_ready held low 6 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, all AXI VALID/READY = 0 throughout. Release -> IDLE next edge.
- Reset mid-write: ARESETN low in N+2 for one edge -> all outputs at reset values next cycle. A subsequent read of 0x05 returns 0x05.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator. Each accepted command becomes one AXI4-Lite
// read or write transaction, and one response is returned on the rsp_* handshake.
module axi_lite_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_write,

    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [ADDR_WIDTH-1:0]     AWADDR,

    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,

    input  logic                      BVALID,
    output logic                      BREADY,
    input  logic [1:0]                BRESP,

    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [ADDR_WIDTH-1:0]     ARADDR,

    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_RESP,
        RD_AR,
        RD_DATA,
        RESP
    } state_e;

    state_e                  state_q,     state_d;
    logic                    awvalid_q,   awvalid_d;
    logic                    wvalid_q,    wvalid_d;
    logic                    arvalid_q,   arvalid_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q,     wstrb_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q,  rsp_resp_d;
    logic                    rsp_write_q, rsp_write_d;

    // A write channel is done once its VALID has dropped or is handshaking on this edge.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_q || AWREADY;
    assign w_done  = !wvalid_q  || WREADY;

    // NOTE: every variable assigned here gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rsp_write_d = cmd_write;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                awvalid_d = !aw_done;
                wvalid_d  = !w_done;
                if (aw_done && w_done) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    rsp_resp_d = BRESP;
                    state_d    = RESP;
                end
            end
            RD_AR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    // Handshake strobes decode from the state register only, never from responder inputs.
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign BREADY    = (state_q == WR_RESP);
    assign RREADY    = (state_q == RD_DATA);

    assign AWVALID   = awvalid_q;
    assign WVALID    = wvalid_q;
    assign ARVALID   = arvalid_q;
    assign AWADDR    = awaddr_q;
    assign ARADDR    = araddr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_write = rsp_write_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a behavioural registered-response BRAM responder plus a
// directly driven stub responder; expected responses flow through a scoreboard queue.
module tb_axi_lite_master;

    logic       ACLK;
    logic       ARESETN;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [0:0] cmd_wstrb;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic       rsp_write;
    logic       AWVALID, AWREADY;
    logic [7:0] AWADDR;
    logic       WVALID, WREADY;
    logic [7:0] WDATA;
    logic [0:0] WSTRB;
    logic       BVALID, BREADY;
    logic [1:0] BRESP;
    logic       ARVALID, ARREADY;
    logic [7:0] ARADDR;
    logic       RVALID, RREADY;
    logic [7:0] RDATA;
    logic [1:0] RRESP;

    axi_lite_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Edge counter: at any point between edges, the current cycle number is e + 1.
    int e = 0;
    always @(posedge ACLK) e <= e + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, e + 1);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] rdata;
        logic [1:0] resp;
        int         cycle;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_busy = 1'b0;

    // BRAM-like responder: single-cycle registered READY, registered B/R, preloaded mem[i] = i.
    logic       stub_mode = 1'b0;
    logic       s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0;
    logic [1:0] s_bresp = 2'b00;
    logic       b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
    logic [7:0] b_rdata;
    logic [7:0] mem [256];
    bit         preloaded = 1'b0;

    always @(posedge ACLK) begin
        if (!ARESETN || stub_mode) begin
            b_awready <= 1'b0;
            b_wready  <= 1'b0;
            b_bvalid  <= 1'b0;
            b_arready <= 1'b0;
            b_rvalid  <= 1'b0;
            b_rdata   <= 8'h00;
            if (!preloaded) begin
                for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
                preloaded <= 1'b1;
            end
        end else begin
            b_awready <= AWVALID && WVALID && !b_awready && !b_bvalid;
            b_wready  <= AWVALID && WVALID && !b_wready && !b_bvalid;
            if (AWVALID && b_awready && WVALID && b_wready) begin
                if (WSTRB[0]) mem[AWADDR] <= WDATA;
                b_bvalid <= 1'b1;
            end else if (b_bvalid && BREADY) begin
                b_bvalid <= 1'b0;
            end
            b_arready <= ARVALID && !b_arready && !b_rvalid;
            if (ARVALID && b_arready) begin
                b_rvalid <= 1'b1;
                b_rdata  <= mem[ARADDR];
            end else if (b_rvalid && RREADY) begin
                b_rvalid <= 1'b0;
            end
        end
    end

    assign AWREADY = stub_mode ? s_awready : b_awready;
    assign WREADY  = stub_mode ? s_wready  : b_wready;
    assign BVALID  = stub_mode ? s_bvalid  : b_bvalid;
    assign BRESP   = stub_mode ? s_bresp   : 2'b00;
    assign ARREADY = stub_mode ? 1'b0      : b_arready;
    assign RVALID  = stub_mode ? 1'b0      : b_rvalid;
    assign RDATA   = b_rdata;
    assign RRESP   = 2'b00;

    // Monitor: pops an expectation when rsp_valid first appears, compares on the handshake.
    initial begin : monitor
        exp_t cur;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                mon_busy = 1'b0;
            end else if (rsp_valid) begin
                if (!mon_busy) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: rsp_valid=1 with no outstanding command (cycle %0d)", e + 1);
                    end else begin
                        cur      = exp_q.pop_front();
                        mon_busy = 1'b1;
                        check("rsp_latency_cycle", 64'(e + 1), 64'(cur.cycle));
                    end
                end
                if (rsp_ready && mon_busy) begin
                    check("rsp_write", rsp_write, cur.wr);
                    check("rsp_rdata", rsp_rdata, cur.rdata);
                    check("rsp_resp",  rsp_resp,  cur.resp);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    function automatic logic [63:0] all_outputs();
        return {22'h0, AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid,
                AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_write};
    endfunction

    // Called just after a rising edge; returns in cycle N+1 (N = accept edge).
    task automatic send(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic strb, input logic [7:0] exp_rdata, input logic [1:0] exp_resp,
                        input int lat, output int n);
        exp_t x;
        int   budget = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        @(negedge ACLK);
        while (!cmd_ready && budget < 100) begin
            @(negedge ACLK);
            budget++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", cmd_ready, 1'b1);
            n = -1;
        end else begin
            n       = e + 1;
            x.wr    = wr;
            x.rdata = exp_rdata;
            x.resp  = exp_resp;
            x.cycle = n + lat;
            exp_q.push_back(x);
        end
        @(posedge ACLK);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge ACLK);
        #2;
    endtask

    initial begin : stimulus
        int n;
        int budget;
        ARESETN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        cmd_wstrb = 1'b0;
        rsp_ready = 1'b1;

        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_outputs", all_outputs(), 64'h0);
        next_cycle();
        ARESETN = 1'b1;
        next_cycle();
        @(negedge ACLK);
        check("cmd_ready_after_release", cmd_ready, 1'b1);
        next_cycle();

        // Plain read of the preloaded pattern.
        send(1'b0, 8'h3C, 8'h00, 1'b0, 8'h3C, 2'b00, 4, n);
        @(negedge ACLK);
        check("arvalid_n1", ARVALID, 1'b1);
        check("araddr_n1", ARADDR, 8'h3C);
        check("cmd_ready_n1", cmd_ready, 1'b0);
        next_cycle();

        // Write then read back; masked write must not change memory.
        send(1'b1, 8'h10, 8'hA5, 1'b1, 8'h3C, 2'b00, 4, n);
        @(negedge ACLK);
        check("aw_w_valid_n1", {AWVALID, WVALID, AWADDR, WDATA}, {2'b11, 8'h10, 8'hA5});
        next_cycle();
        send(1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, 2'b00, 4, n);
        send(1'b1, 8'h20, 8'hFF, 1'b0, 8'hA5, 2'b00, 4, n);
        send(1'b0, 8'h20, 8'h00, 1'b0, 8'h20, 2'b00, 4, n);

        // Split write channels against the stub, BVALID already waiting with SLVERR.
        budget = 0;
        while ((mon_busy || exp_q.size() != 0) && budget < 50) begin
            next_cycle();
            budget++;
        end
        stub_mode = 1'b1;
        send(1'b1, 8'h30, 8'h77, 1'b1, 8'h20, 2'b10, 6, n);
        s_awready = 1'b1;
        s_bvalid  = 1'b1;
        s_bresp   = 2'b10;
        @(negedge ACLK);
        check("split_n1_valids", {AWVALID, WVALID}, 2'b11);
        next_cycle();
        s_awready = 1'b0;
        @(negedge ACLK);
        check("split_n2_valids", {AWVALID, WVALID, BREADY}, 3'b010);
        next_cycle();
        @(negedge ACLK);
        check("split_n3_valids", {AWVALID, WVALID, BREADY}, 3'b010);
        next_cycle();
        s_wready = 1'b1;
        @(negedge ACLK);
        check("split_n4_valids", {AWVALID, WVALID, BREADY}, 3'b010);
        check("split_n4_wdata_awaddr", {WDATA, AWADDR}, {8'h77, 8'h30});
        next_cycle();
        s_wready = 1'b0;
        @(negedge ACLK);
        check("split_n5_bready", {WVALID, BREADY}, 2'b01);
        next_cycle();
        s_bvalid = 1'b0;
        @(negedge ACLK);
        check("split_n6_bready_low", BREADY, 1'b0);
        next_cycle();
        stub_mode = 1'b0;
        s_bresp   = 2'b00;
        next_cycle();

        // Response back-pressure for 6 cycles.
        rsp_ready = 1'b0;
        send(1'b0, 8'h3C, 8'h00, 1'b0, 8'h3C, 2'b00, 4, n);
        repeat (3) @(posedge ACLK);
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            check("bp_rsp_valid_data", {rsp_valid, rsp_rdata, cmd_ready}, {1'b1, 8'h3C, 1'b0});
            check("bp_axi_quiet", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
        end
        next_cycle();
        rsp_ready = 1'b1;
        @(negedge ACLK);
        check("bp_cmd_ready_at_release", cmd_ready, 1'b0);
        @(negedge ACLK);
        check("bp_cmd_ready_after", cmd_ready, 1'b1);
        next_cycle();

        // Reset in the middle of a write, then a fresh read.
        send(1'b1, 8'h08, 8'h55, 1'b1, 8'h3C, 2'b00, 4, n);
        next_cycle();
        ARESETN = 1'b0;
        exp_q.delete();
        next_cycle();
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("midreset_outputs", all_outputs(), 64'h0);
        check("midreset_cmd_ready", cmd_ready, 1'b1);
        next_cycle();
        send(1'b0, 8'h05, 8'h00, 1'b0, 8'h05, 2'b00, 4, n);

        budget = 0;
        while ((mon_busy || exp_q.size() != 0) && budget < 100) begin
            next_cycle();
            budget++;
        end
        if (mon_busy || exp_q.size() != 0) begin
            check("drain_timeout_outstanding", 64'(exp_q.size() + int'(mon_busy)), 64'h0);
        end
        repeat (2) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
